// File: rtl/bias_add_7_pkg.sv
// -----------------------------------------------------------------------------
// bias_add_7_pkg
// Shared definitions for the layer-7 bias/rescale/saturate stage.
//   - Layer-7 geometry and word widths (kernel count, pixels, bias/acc/out width)
//   - FSM state encoding for the top level
//   - Counter-width helper that never returns a zero-width vector
// -----------------------------------------------------------------------------
package bias_add_7_pkg;

    // Layer-7 geometry
    localparam int kern_s_k_7   = 4;
    localparam int pixels_s_k_7 = 64;

    // Word widths for layer 7
    localparam int coeff_width  = 16;
    localparam int acc_width_7  = 32;
    localparam int out_width_7  = 16;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Width of a counter over n values; at least 1 bit so n == 1 stays legal.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/bias_add_7_sat.sv
// -----------------------------------------------------------------------------
// bias_add_sat
// Purely combinational datapath: sign-extend accumulator and bias to ACC_W+1
// bits, add, arithmetic right shift by SHIFT (rounds toward -inf), optional
// ReLU, then saturate into a signed OUT_W result.
// Ports:
//   acc_i  [ACC_W-1:0]   signed accumulator word
//   bias_i [COEFF_W-1:0] signed bias for the accumulator's channel
//   res_o  [OUT_W-1:0]   signed, saturated result
// -----------------------------------------------------------------------------
module bias_add_sat
    import bias_add_7_pkg::*;
#(
    parameter int COEFF_W = coeff_width,
    parameter int ACC_W   = acc_width_7,
    parameter int OUT_W   = out_width_7,
    parameter int SHIFT   = 8,
    parameter int RELU    = 1
) (
    input  logic signed [ACC_W-1:0]   acc_i,
    input  logic signed [COEFF_W-1:0] bias_i,
    output logic signed [OUT_W-1:0]   res_o
);

    // One guard bit is enough: COEFF_W <= ACC_W, so the sum cannot overflow.
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    // Two's complement: ~MAX == -MAX-1 == -2^(OUT_W-1)
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] shr_s;
    logic signed [SW-1:0] clip_s;

    // Add, shift, ReLU and saturate
    always_comb begin
        sum_s = $signed({acc_i[ACC_W-1], acc_i})
              + $signed({{(SW - COEFF_W){bias_i[COEFF_W-1]}}, bias_i});
        shr_s = sum_s >>> SHIFT;
        if ((RELU != 0) && shr_s[SW-1]) begin
            clip_s = {SW{1'b0}};
        end else if (shr_s > SAT_MAX) begin
            clip_s = SAT_MAX;
        end else if (shr_s < SAT_MIN) begin
            clip_s = SAT_MIN;
        end else begin
            clip_s = shr_s;
        end
        res_o = clip_s[OUT_W-1:0];
    end

endmodule

// File: rtl/bias_add_7.sv
// -----------------------------------------------------------------------------
// bias_add_7
// Layer-7 bias stage. Each frame first loads KERN biases from the bias FIFO
// (LOAD), then streams KERN*PIXELS accumulator words (RUN, channel innermost),
// adding the channel's bias, rescaling, ReLU and saturating via bias_add_sat.
// Results go out through a one-word output register with HLS FIFO handshake.
// Ports:
//   ap_clk, ap_rst                 clock, synchronous active-high reset
//   bias_V_dout/_empty_n/_read     bias FIFO read side
//   acc_V_dout/_empty_n/_read      accumulator FIFO read side
//   output_V_din/_full_n/_write    next-layer FIFO write side
// -----------------------------------------------------------------------------
module bias_add_7
    import bias_add_7_pkg::*;
#(
    parameter int KERN    = kern_s_k_7,
    parameter int PIXELS  = 64,
    parameter int COEFF_W = coeff_width,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 8,
    parameter int RELU    = 1
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   acc_V_dout,
    input  logic               acc_V_empty_n,
    output logic               acc_V_read,
    output logic [OUT_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);

    localparam int KW = cnt_width(KERN);
    localparam int PW = cnt_width(PIXELS);
    localparam logic [KW-1:0] K_LAST = KW'(KERN - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PIXELS - 1);

    state_e             state_q;
    logic [KW-1:0]      bidx_q;
    logic [KW-1:0]      ch_q;
    logic [PW-1:0]      pix_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_din_q;
    logic [COEFF_W-1:0] bias_q [KERN];

    logic               bias_rd_s;
    logic               acc_rd_s;
    logic [COEFF_W-1:0] bias_sel_s;
    logic [OUT_W-1:0]   res_d;

    // FIFO pop strobes: only registered state and handshake flags feed these
    always_comb begin
        bias_rd_s = 1'b0;
        acc_rd_s  = 1'b0;
        if (ap_rst) begin
            bias_rd_s = 1'b0;
            acc_rd_s  = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: bias_rd_s = bias_V_empty_n;
                // A pop is allowed when the output register is free or drains this cycle
                ST_RUN:  acc_rd_s  = acc_V_empty_n && (!out_valid_q || output_V_full_n);
                default: begin
                    bias_rd_s = 1'b0;
                    acc_rd_s  = 1'b0;
                end
            endcase
        end
    end

    assign bias_sel_s = bias_q[ch_q];

    bias_add_sat #(
        .COEFF_W (COEFF_W),
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .RELU    (RELU)
    ) u_sat (
        .acc_i  (acc_V_dout),
        .bias_i (bias_sel_s),
        .res_o  (res_d)
    );

    // Bias register file: no reset, every frame reloads it before RUN reads it
    always_ff @(posedge ap_clk) begin
        if (bias_rd_s) begin
            bias_q[bidx_q] <= bias_V_dout;
        end
    end

    // FSM, frame counters and output register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_LOAD;
            bidx_q      <= {KW{1'b0}};
            ch_q        <= {KW{1'b0}};
            pix_q       <= {PW{1'b0}};
            out_valid_q <= 1'b0;
            out_din_q   <= {OUT_W{1'b0}};
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bias_rd_s) begin
                        if (bidx_q == K_LAST) begin
                            bidx_q  <= {KW{1'b0}};
                            state_q <= ST_RUN;
                        end else begin
                            bidx_q <= bidx_q + KW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (acc_rd_s) begin
                        if (ch_q == K_LAST) begin
                            ch_q <= {KW{1'b0}};
                            if (pix_q == P_LAST) begin
                                pix_q   <= {PW{1'b0}};
                                state_q <= ST_LOAD;
                            end else begin
                                pix_q <= pix_q + PW'(1);
                            end
                        end else begin
                            ch_q <= ch_q + KW'(1);
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase

            // A pop always refills; otherwise a transferred word empties the register.
            // The output side runs independently of LOAD at frame boundaries.
            if (acc_rd_s) begin
                out_din_q   <= res_d;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && output_V_full_n) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bias_V_read    = bias_rd_s;
    assign acc_V_read     = acc_rd_s;
    assign output_V_write = out_valid_q;
    assign output_V_din   = out_din_q;

endmodule

// File: tb/tb_bias_add_7.sv
// -----------------------------------------------------------------------------
// tb_bias_add_7
// Self-checking bench for bias_add_7 (KERN=4, PIXELS=2, SHIFT=8). Two DUT
// copies share all inputs: one with RELU=1, one with RELU=0. FIFO sources are
// bench queues; expected results are queued when a frame is pushed and popped
// whenever the DUT transfers a word.
// -----------------------------------------------------------------------------
module tb_bias_add_7;

    localparam int KERN    = 4;
    localparam int PIXELS  = 2;
    localparam int COEFF_W = 16;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 16;
    localparam int SHIFT   = 8;
    localparam int NWORDS  = KERN * PIXELS;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic [COEFF_W-1:0] bias_V_dout = '0;
    logic               bias_V_empty_n = 1'b0;
    logic [ACC_W-1:0]   acc_V_dout = '0;
    logic               acc_V_empty_n = 1'b0;
    logic               output_V_full_n = 1'b1;

    logic               bias_V_read, acc_V_read, output_V_write;
    logic [OUT_W-1:0]   output_V_din;
    logic               bias_V_read_nr, acc_V_read_nr, output_V_write_nr;
    logic [OUT_W-1:0]   output_V_din_nr;

    bias_add_7 #(.KERN(KERN), .PIXELS(PIXELS), .COEFF_W(COEFF_W), .ACC_W(ACC_W),
                 .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(1)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
        .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read),
        .output_V_din(output_V_din), .output_V_full_n(output_V_full_n),
        .output_V_write(output_V_write)
    );

    bias_add_7 #(.KERN(KERN), .PIXELS(PIXELS), .COEFF_W(COEFF_W), .ACC_W(ACC_W),
                 .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(0)) dut_nr (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read_nr),
        .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read_nr),
        .output_V_din(output_V_din_nr), .output_V_full_n(output_V_full_n),
        .output_V_write(output_V_write_nr)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    logic [COEFF_W-1:0] bias_src [$];
    logic [ACC_W-1:0]   acc_src  [$];
    int                 exp_q    [$];
    int                 exp_nr_q [$];

    bit   gap_en  = 1'b0;
    int   bp_hold = 0;
    int   out_cnt = 0;
    int   frame_bias_cnt = 0;
    int   frame_acc_cnt  = 0;
    bit   prev_pop  = 1'b0;
    bit   prev_hold = 1'b0;
    logic [OUT_W-1:0] prev_din = '0;

    logic [COEFF_W-1:0] B1 [KERN]   = '{16'h0100, 16'hFE00, 16'h0000, 16'h03E8};
    logic [ACC_W-1:0]   A1 [NWORDS] = '{32'd1024, 32'd0, 32'h7FFF0000, 32'd24,
                                        32'hFFFFFED4, 32'd100000, 32'h80000000, 32'hFFFFFC18};
    logic [ACC_W-1:0]   AS [NWORDS] = '{32'd0, 32'd0, 32'h7FFF0000, 32'd0,
                                        32'd0, 32'd0, 32'h80000000, 32'd0};
    logic [COEFF_W-1:0] B2 [KERN]   = '{16'hFF00, 16'd7, 16'hFFF9, 16'd12345};
    logic [ACC_W-1:0]   A2 [NWORDS] = '{32'd1024, 32'd5000, 32'd256, 32'hFFFF0000,
                                        32'd77, 32'h00100000, 32'd3, 32'd999};
    logic [COEFF_W-1:0] B3 [KERN]   = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [ACC_W-1:0]   A3 [NWORDS] = '{32'd2000, 32'd3000, 32'hFFFFF000, 32'd40000,
                                        32'd1, 32'd2, 32'd3, 32'd4};

    // Reference arithmetic in 64-bit integers
    function automatic int model(input logic [ACC_W-1:0] acc, input logic [COEFF_W-1:0] bias,
                                 input bit relu);
        longint s;
        longint t;
        s = longint'($signed(acc)) + longint'($signed(bias));
        t = s >>> SHIFT;
        if (relu && t < 0) t = 0;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return int'(t);
    endfunction

    // FIFO sources, output sink and scoreboard
    initial begin : fifo_model
        forever begin
            @(negedge ap_clk);
            bias_V_empty_n = (bias_src.size() > 0) && (!gap_en || $urandom_range(0, 2) != 0);
            bias_V_dout    = (bias_src.size() > 0) ? bias_src[0] : 16'h0000;
            acc_V_empty_n  = (acc_src.size() > 0) && (!gap_en || $urandom_range(0, 2) != 0);
            acc_V_dout     = (acc_src.size() > 0) ? acc_src[0] : 32'h0;
            if (bp_hold > 0) begin
                output_V_full_n = 1'b0;
                bp_hold = bp_hold - 1;
            end else begin
                output_V_full_n = !gap_en || ($urandom_range(0, 3) != 0);
            end
            #1;
            if (ap_rst) begin
                prev_pop  = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (prev_pop) begin
                    checks++;
                    if (output_V_write !== 1'b1) begin
                        errors++;
                        $display("FAIL latency: write=%b, required 1 one cycle after pop", output_V_write);
                    end
                end
                if (prev_hold) begin
                    checks++;
                    if (output_V_write !== 1'b1 || output_V_din !== prev_din) begin
                        errors++;
                        $display("FAIL hold: write=%b din=%h, required write=1 din=%h",
                                 output_V_write, output_V_din, prev_din);
                    end
                end
                if (bias_V_read === 1'b1) begin
                    checks++;
                    if (frame_bias_cnt >= KERN || bias_src.size() == 0) begin
                        errors++;
                        $display("FAIL bias_pop: popped with %0d biases loaded, %0d queued, required LOAD with data",
                                 frame_bias_cnt, bias_src.size());
                    end else begin
                        void'(bias_src.pop_front());
                        frame_bias_cnt++;
                    end
                end
                if (acc_V_read === 1'b1) begin
                    checks++;
                    if (frame_bias_cnt != KERN || acc_src.size() == 0) begin
                        errors++;
                        $display("FAIL acc_pop: popped with %0d biases loaded, %0d queued, required %0d biases and data",
                                 frame_bias_cnt, acc_src.size(), KERN);
                    end else begin
                        void'(acc_src.pop_front());
                        frame_acc_cnt++;
                        if (frame_acc_cnt == NWORDS) begin
                            frame_acc_cnt  = 0;
                            frame_bias_cnt = 0;
                        end
                    end
                end
                if (output_V_write === 1'b1 && output_V_full_n) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_output: din=%h, required no transfer", output_V_din);
                    end else begin
                        int e;
                        int en;
                        logic [OUT_W-1:0] e16;
                        logic [OUT_W-1:0] en16;
                        e    = exp_q.pop_front();
                        en   = exp_nr_q.pop_front();
                        e16  = OUT_W'(e);
                        en16 = OUT_W'(en);
                        if (output_V_din !== e16 || output_V_din_nr !== en16 || output_V_write_nr !== 1'b1) begin
                            errors++;
                            $display("FAIL data: relu=%0d norelu=%0d wr_nr=%b, required relu=%0d norelu=%0d",
                                     $signed(output_V_din), $signed(output_V_din_nr), output_V_write_nr, e, en);
                        end
                        out_cnt++;
                    end
                end
                prev_pop  = (acc_V_read === 1'b1);
                prev_hold = (output_V_write === 1'b1) && !output_V_full_n;
                prev_din  = output_V_din;
            end
        end
    end

    task automatic push_biases(input logic [COEFF_W-1:0] b [KERN]);
        @(posedge ap_clk);
        for (int i = 0; i < KERN; i++) bias_src.push_back(b[i]);
    endtask

    task automatic push_accs(input logic [COEFF_W-1:0] b [KERN], input logic [ACC_W-1:0] a [NWORDS]);
        @(posedge ap_clk);
        for (int i = 0; i < NWORDS; i++) begin
            acc_src.push_back(a[i]);
            exp_q.push_back(model(a[i], b[i % KERN], 1'b1));
            exp_nr_q.push_back(model(a[i], b[i % KERN], 1'b0));
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(bias_src.size() == 0 && acc_src.size() == 0 && exp_q.size() == 0) && n < budget) begin
            @(negedge ap_clk);
            #2;
            n++;
        end
        checks++;
        if (!(bias_src.size() == 0 && acc_src.size() == 0 && exp_q.size() == 0)) begin
            errors++;
            $display("FAIL %s_timeout: %0d bias, %0d acc, %0d results pending, required 0",
                     name, bias_src.size(), acc_src.size(), exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (output_V_write !== 1'b0 || output_V_din !== 16'h0000 ||
            bias_V_read !== 1'b0 || acc_V_read !== 1'b0) begin
            errors++;
            $display("FAIL %s: write=%b din=%h bias_rd=%b acc_rd=%b, required all 0",
                     name, output_V_write, output_V_din, bias_V_read, acc_V_read);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            #2;
            check_reset_outputs("reset");
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic test_normal_frame();
        push_biases(B1);
        push_accs(B1, A1);
        wait_drain(200, "normal");
    endtask

    task automatic test_saturation();
        push_biases(B1);
        push_accs(B1, AS);
        wait_drain(200, "saturation");
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [OUT_W-1:0] held;
        push_biases(B1);
        push_accs(B1, A1);
        while (output_V_write !== 1'b1 && n < 50) begin
            @(negedge ap_clk);
            #2;
            n++;
        end
        @(posedge ap_clk);
        bp_hold = 5;
        @(negedge ap_clk);
        #2;
        held = output_V_din;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (acc_V_read !== 1'b0 || output_V_write !== 1'b1 || output_V_din !== held) begin
                errors++;
                $display("FAIL backpressure: acc_rd=%b write=%b din=%h, required 0/1/%h",
                         acc_V_read, output_V_write, output_V_din, held);
            end
            @(negedge ap_clk);
            #2;
        end
        wait_drain(200, "backpressure");
    endtask

    task automatic test_frame_wrap();
        push_accs(B2, A2);
        for (int i = 0; i < 6; i++) begin
            @(negedge ap_clk);
            #2;
            checks++;
            if (acc_V_read !== 1'b0) begin
                errors++;
                $display("FAIL wrap_no_acc: acc_rd=%b before biases, required 0", acc_V_read);
            end
        end
        push_biases(B2);
        wait_drain(200, "frame_wrap");
    endtask

    task automatic test_empty_stalls();
        gap_en = 1'b1;
        push_biases(B1);
        push_accs(B1, A1);
        wait_drain(600, "empty_stalls");
        gap_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int base;
        int n = 0;
        push_biases(B1);
        push_accs(B1, A1);
        base = out_cnt;
        while (out_cnt < base + 3 && n < 100) begin
            @(negedge ap_clk);
            #2;
            n++;
        end
        checks++;
        if (out_cnt < base + 3) begin
            errors++;
            $display("FAIL midrun_outputs: %0d outputs, required 3", out_cnt - base);
        end
        @(negedge ap_clk);
        ap_rst = 1'b1;
        bias_src.delete();
        acc_src.delete();
        exp_q.delete();
        exp_nr_q.delete();
        frame_bias_cnt = 0;
        frame_acc_cnt  = 0;
        repeat (2) begin
            @(negedge ap_clk);
            #2;
            check_reset_outputs("midrun_reset");
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        push_biases(B3);
        push_accs(B3, A3);
        wait_drain(200, "after_reset");
    endtask

    initial begin : main
        test_reset();
        test_normal_frame();
        test_saturation();
        test_backpressure();
        test_frame_wrap();
        test_empty_stalls();
        test_reset_mid_run();
        repeat (4) @(negedge ap_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
